// File: rtl/dds_cmd_pkg.sv
// Shared constants and state encoding for the UART-to-DDS command sequencer.
package dds_cmd_pkg;

    localparam logic [7:0] OP_FTW   = 8'h01;
    localparam logic [7:0] OP_PHASE = 8'h02;
    localparam logic [7:0] OP_AMP   = 8'h03;
    localparam logic [7:0] OP_WAVE  = 8'h04;
    localparam logic [7:0] OP_EN    = 8'h05;
    localparam logic [7:0] OP_LED   = 8'h08;

    localparam logic [2:0] REG_FTW   = 3'd0;
    localparam logic [2:0] REG_PHASE = 3'd1;
    localparam logic [2:0] REG_AMP   = 3'd2;
    localparam logic [2:0] REG_WAVE  = 3'd3;
    localparam logic [2:0] REG_EN    = 3'd4;

    localparam logic [7:0] ST_OK_BASE = 8'hA0;
    localparam logic [7:0] ST_BADCH   = 8'hEC;
    localparam logic [7:0] ST_BADOP   = 8'hEE;
    localparam logic [7:0] ST_TMO     = 8'hEF;

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        WRITE,
        ACK_WAIT,
        ACK
    } state_t;

endpackage

// File: rtl/dds_cmd_decode.sv
// Combinational opcode/channel decode into a config-bus write and its status byte.
module dds_cmd_decode
    import dds_cmd_pkg::*;
#(
    parameter int NUM_CH = 2
) (
    input  logic [7:0]  opcode,
    input  logic [3:0]  ch,
    input  logic [3:0]  arg,
    input  logic [15:0] data_hi,
    input  logic [15:0] data_lo,
    output logic        legal,
    output logic        is_led,
    output logic [2:0]  addr,
    output logic [31:0] wdata,
    output logic [7:0]  status
);

    always_comb begin
        logic write_op;
        write_op = 1'b1;
        legal    = 1'b0;
        is_led   = 1'b0;
        addr     = 3'd0;
        wdata    = 32'd0;
        status   = ST_BADOP;

        case (opcode)
            OP_FTW: begin
                addr  = REG_FTW;
                wdata = {data_hi, data_lo};
            end
            OP_PHASE: begin
                addr  = REG_PHASE;
                wdata = {16'h0, data_hi};
            end
            OP_AMP: begin
                addr  = REG_AMP;
                wdata = {20'h0, data_lo[11:0]};
            end
            OP_WAVE: begin
                addr  = REG_WAVE;
                wdata = {30'h0, arg[1:0]};
            end
            OP_EN: begin
                addr  = REG_EN;
                wdata = {31'h0, arg[0]};
            end
            OP_LED: begin
                write_op = 1'b0;
                is_led   = 1'b1;
                status   = ST_OK_BASE | OP_LED;
            end
            default: write_op = 1'b0;
        endcase

        // The channel range only matters for opcodes that touch the DDS bus
        if (write_op) begin
            if (int'(ch) < NUM_CH) begin
                legal  = 1'b1;
                status = ST_OK_BASE | {4'h0, opcode[3:0]};
            end else begin
                status = ST_BADCH;
            end
        end
    end

endmodule

// File: rtl/uart_dds_cmd_ctrl.sv
// Packet-to-register-write sequencer: owns the DDS config bus and returns a status byte per packet.
module uart_dds_cmd_ctrl
    import dds_cmd_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int TIMEOUT_CYC = 1000,
    parameter int CNT_W       = 10
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        recv_done,
    input  logic [7:0]  dataA,
    input  logic [15:0] dataB,
    input  logic [15:0] dataC,
    input  logic [7:0]  dataD,
    output logic        cfg_valid,
    input  logic        cfg_ready,
    output logic [3:0]  cfg_ch,
    output logic [2:0]  cfg_addr,
    output logic [31:0] cfg_wdata,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    input  logic        tx_busy,
    output logic        led,
    output logic        cmd_drop
);

    state_t             state;
    logic [7:0]         op_q;
    logic [15:0]        b_q;
    logic [15:0]        c_q;
    logic [7:0]         d_q;
    logic [7:0]         status_q;
    logic [CNT_W-1:0]   tmo_cnt;

    logic               dec_legal;
    logic               dec_is_led;
    logic [2:0]         dec_addr;
    logic [31:0]        dec_wdata;
    logic [7:0]         dec_status;

    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

    dds_cmd_decode #(.NUM_CH(NUM_CH)) u_decode (
        .opcode  (op_q),
        .ch      (d_q[7:4]),
        .arg     (d_q[3:0]),
        .data_hi (b_q),
        .data_lo (c_q),
        .legal   (dec_legal),
        .is_led  (dec_is_led),
        .addr    (dec_addr),
        .wdata   (dec_wdata),
        .status  (dec_status)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= IDLE;
            op_q      <= '0;
            b_q       <= '0;
            c_q       <= '0;
            d_q       <= '0;
            status_q  <= '0;
            tmo_cnt   <= '0;
            cfg_valid <= 1'b0;
            cfg_ch    <= '0;
            cfg_addr  <= '0;
            cfg_wdata <= '0;
            tx_start  <= 1'b0;
            tx_data   <= '0;
            led       <= 1'b0;
            cmd_drop  <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            cmd_drop <= recv_done && (state != IDLE);

            case (state)
                IDLE: begin
                    if (recv_done) begin
                        op_q  <= dataA;
                        b_q   <= dataB;
                        c_q   <= dataC;
                        d_q   <= dataD;
                        state <= DECODE;
                    end
                end
                DECODE: begin
                    status_q <= dec_status;
                    if (dec_legal) begin
                        cfg_ch    <= d_q[7:4];
                        cfg_addr  <= dec_addr;
                        cfg_wdata <= dec_wdata;
                        cfg_valid <= 1'b1;
                        tmo_cnt   <= '0;
                        state     <= WRITE;
                    end else begin
                        if (dec_is_led)
                            led <= d_q[0];
                        state <= ACK_WAIT;
                    end
                end
                WRITE: begin
                    // A handshake on the final allowed cycle still counts as success
                    if (cfg_ready) begin
                        cfg_valid <= 1'b0;
                        state     <= ACK_WAIT;
                    end else if (tmo_cnt == TMO_LAST) begin
                        cfg_valid <= 1'b0;
                        status_q  <= ST_TMO;
                        state     <= ACK_WAIT;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                ACK_WAIT: begin
                    if (!tx_busy) begin
                        tx_start <= 1'b1;
                        tx_data  <= status_q;
                        state    <= ACK;
                    end
                end
                ACK:      state <= IDLE;
                default:  state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_dds_cmd_ctrl.sv
// Directed self-checking bench for uart_dds_cmd_ctrl with hand-computed expectations.
module tb_uart_dds_cmd_ctrl;

    localparam int TIMEOUT_CYC = 1000;

    logic        sys_clk   = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        recv_done = 1'b0;
    logic [7:0]  dataA     = '0;
    logic [15:0] dataB     = '0;
    logic [15:0] dataC     = '0;
    logic [7:0]  dataD     = '0;
    logic        cfg_ready = 1'b1;
    logic        tx_busy   = 1'b0;
    logic        cfg_valid;
    logic [3:0]  cfg_ch;
    logic [2:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        led;
    logic        cmd_drop;

    int checks = 0;
    int errors = 0;

    int wr_count     = 0;
    int tx_count     = 0;
    int drop_count   = 0;
    int valid_cycles = 0;
    logic [3:0]  last_ch          = '0;
    logic [2:0]  last_addr        = '0;
    logic [31:0] last_wdata       = '0;
    logic [31:0] last_valid_wdata = '0;
    logic [7:0]  last_tx          = '0;

    uart_dds_cmd_ctrl #(.NUM_CH(2), .TIMEOUT_CYC(TIMEOUT_CYC), .CNT_W(10)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .recv_done (recv_done),
        .dataA     (dataA),
        .dataB     (dataB),
        .dataC     (dataC),
        .dataD     (dataD),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .tx_busy   (tx_busy),
        .led       (led),
        .cmd_drop  (cmd_drop)
    );

    always #5 sys_clk = ~sys_clk;

    // Bus and UART activity recorder, sampled mid-cycle
    always @(negedge sys_clk) begin
        if (cfg_valid) begin
            valid_cycles++;
            last_valid_wdata = cfg_wdata;
            if (cfg_ready) begin
                wr_count++;
                last_ch    = cfg_ch;
                last_addr  = cfg_addr;
                last_wdata = cfg_wdata;
            end
        end
        if (tx_start) begin
            tx_count++;
            last_tx = tx_data;
        end
        if (cmd_drop)
            drop_count++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] a, input logic [15:0] b,
                                 input logic [15:0] c, input logic [7:0] d);
        @(negedge sys_clk);
        dataA     = a;
        dataB     = b;
        dataC     = c;
        dataD     = d;
        recv_done = 1'b1;
        @(negedge sys_clk);
        recv_done = 1'b0;
    endtask

    task automatic waitTx(input string tag, input int max_cyc);
        int base = tx_count;
        for (int i = 0; i < max_cyc && tx_count == base; i++)
            @(posedge sys_clk);
        checkOutput(tag, 32'(tx_count - base), 32'd1);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        int base_w;
        int base_t;
        int base_v;
        int base_d;

        repeat (3) @(negedge sys_clk);
        checkOutput("rst_cfg_valid", 32'(cfg_valid), 32'd0);
        checkOutput("rst_cfg_ch",    32'(cfg_ch),    32'd0);
        checkOutput("rst_cfg_addr",  32'(cfg_addr),  32'd0);
        checkOutput("rst_cfg_wdata", cfg_wdata,      32'd0);
        checkOutput("rst_tx_start",  32'(tx_start),  32'd0);
        checkOutput("rst_tx_data",   32'(tx_data),   32'd0);
        checkOutput("rst_led",       32'(led),       32'd0);
        checkOutput("rst_cmd_drop",  32'(cmd_drop),  32'd0);
        sys_rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);

        $display("[TB] FTW write and latency");
        dataA = 8'h01; dataB = 16'h1234; dataC = 16'h5678; dataD = 8'h10;
        recv_done = 1'b1;
        @(negedge sys_clk);
        recv_done = 1'b0;
        checkOutput("lat_n1_valid", 32'(cfg_valid), 32'd0);
        @(negedge sys_clk);
        checkOutput("lat_n2_valid", 32'(cfg_valid), 32'd1);
        checkOutput("ftw_ch",       32'(cfg_ch),    32'd1);
        checkOutput("ftw_addr",     32'(cfg_addr),  32'd0);
        checkOutput("ftw_wdata",    cfg_wdata,      32'h1234_5678);
        @(negedge sys_clk);
        checkOutput("lat_n3_valid", 32'(cfg_valid), 32'd0);
        checkOutput("lat_n3_tx",    32'(tx_start),  32'd0);
        @(negedge sys_clk);
        checkOutput("lat_n4_tx",    32'(tx_start),  32'd1);
        checkOutput("ftw_status",   32'(tx_data),   32'hA1);
        @(negedge sys_clk);
        checkOutput("lat_n5_tx",    32'(tx_start),  32'd0);
        checkOutput("ftw_wr_count", 32'(wr_count),  32'd1);

        $display("[TB] LED on/off");
        base_w = wr_count;
        applyStimulus(8'h08, 16'h0, 16'h0, 8'h01);
        waitTx("led_on_tx", 20);
        checkOutput("led_on",        32'(led),      32'd1);
        checkOutput("led_on_status", 32'(last_tx),  32'hA8);
        applyStimulus(8'h08, 16'h0, 16'h0, 8'h00);
        waitTx("led_off_tx", 20);
        checkOutput("led_off",       32'(led),      32'd0);
        checkOutput("led_no_write",  32'(wr_count), 32'(base_w));

        $display("[TB] bad channel and bad opcode");
        base_v = valid_cycles;
        applyStimulus(8'h02, 16'hBEEF, 16'h0, 8'h30);
        waitTx("badch_tx", 20);
        checkOutput("badch_status",   32'(last_tx),      32'hEC);
        applyStimulus(8'h7F, 16'h0, 16'h0, 8'h00);
        waitTx("badop_tx", 20);
        checkOutput("badop_status",   32'(last_tx),      32'hEE);
        checkOutput("bad_no_valid",   32'(valid_cycles), 32'(base_v));

        $display("[TB] timeout without ready");
        base_w = wr_count;
        base_v = valid_cycles;
        cfg_ready = 1'b0;
        applyStimulus(8'h03, 16'h0, 16'hFABC, 8'h10);
        waitTx("tmo_tx", TIMEOUT_CYC + 100);
        checkOutput("tmo_valid_cycles", 32'(valid_cycles - base_v), 32'(TIMEOUT_CYC));
        checkOutput("tmo_wdata",        last_valid_wdata,           32'h0000_0ABC);
        checkOutput("tmo_status",       32'(last_tx),               32'hEF);
        checkOutput("tmo_no_write",     32'(wr_count),              32'(base_w));

        $display("[TB] ready on the last allowed cycle");
        base_v = valid_cycles;
        applyStimulus(8'h03, 16'h0, 16'h0123, 8'h00);
        for (int i = 0; i < TIMEOUT_CYC + 100 && (valid_cycles - base_v) < TIMEOUT_CYC - 1; i++) begin
            @(posedge sys_clk);
            #1;
        end
        cfg_ready = 1'b1;
        waitTx("last_tx", 20);
        checkOutput("last_valid_cycles", 32'(valid_cycles - base_v), 32'(TIMEOUT_CYC));
        checkOutput("last_status",       32'(last_tx),               32'hA3);
        checkOutput("last_write",        32'(wr_count),              32'(base_w + 1));
        checkOutput("last_addr",         32'(last_addr),             32'd2);
        checkOutput("last_wdata",        last_wdata,                 32'h0000_0123);

        $display("[TB] tx_busy stall and dropped packet");
        base_w = wr_count;
        base_t = tx_count;
        base_d = drop_count;
        tx_busy = 1'b1;
        applyStimulus(8'h01, 16'hAAAA, 16'h5555, 8'h00);
        repeat (3) @(negedge sys_clk);
        applyStimulus(8'h05, 16'h0, 16'h0, 8'h01);
        repeat (45) @(negedge sys_clk);
        checkOutput("busy_no_tx",   32'(tx_count),   32'(base_t));
        checkOutput("busy_drop",    32'(drop_count), 32'(base_d + 1));
        checkOutput("busy_one_wr",  32'(wr_count),   32'(base_w + 1));
        checkOutput("busy_wdata",   last_wdata,      32'hAAAA_5555);
        tx_busy = 1'b0;
        waitTx("busy_tx", 10);
        checkOutput("busy_status",  32'(last_tx),    32'hA1);
        repeat (20) @(negedge sys_clk);
        checkOutput("busy_tx_once", 32'(tx_count),   32'(base_t + 1));
        checkOutput("busy_wr_once", 32'(wr_count),   32'(base_w + 1));

        $display("[TB] reset during write");
        applyStimulus(8'h08, 16'h0, 16'h0, 8'h01);
        waitTx("pre_rst_led_tx", 20);
        cfg_ready = 1'b0;
        applyStimulus(8'h02, 16'h55AA, 16'h0, 8'h00);
        for (int i = 0; i < 10 && !cfg_valid; i++) begin
            @(posedge sys_clk);
            #1;
        end
        checkOutput("rst_pre_valid", 32'(cfg_valid), 32'd1);
        #2;
        sys_rst_n = 1'b0;
        #1;
        checkOutput("rst_async_valid", 32'(cfg_valid), 32'd0);
        checkOutput("rst_async_txd",   32'(tx_data),   32'd0);
        checkOutput("rst_async_led",   32'(led),       32'd0);
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        cfg_ready = 1'b1;
        base_t = tx_count;
        repeat (10) @(negedge sys_clk);
        checkOutput("rst_no_stale_tx", 32'(tx_count), 32'(base_t));
        applyStimulus(8'h04, 16'h0, 16'h0, 8'h13);
        waitTx("post_rst_tx", 20);
        checkOutput("post_rst_ch",     32'(last_ch),    32'd1);
        checkOutput("post_rst_addr",   32'(last_addr),  32'd3);
        checkOutput("post_rst_wdata",  last_wdata,      32'h0000_0003);
        checkOutput("post_rst_status", 32'(last_tx),    32'hA4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
